// File: rtl/sh7604_stby_ctrl_pkg.sv
// rtl/sh7604_stby_ctrl_pkg.sv - shared types and settle-timer tap table for the standby sequencer
package sh7604_stby_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_SLEEP  = 3'd2,
        ST_STBY   = 3'd3,
        ST_SETTLE = 3'd4
    } stby_state_t;

    localparam int PRESC_W = 13;

    // Highest prescaler bit index that must be set for a counter tick; divide = 2^(tap+1).
    function automatic logic [3:0] cks_tap(input logic [2:0] cks);
        logic [3:0] tap;
        case (cks)
            3'd0:    tap = 4'd0;
            3'd1:    tap = 4'd5;
            3'd2:    tap = 4'd6;
            3'd3:    tap = 4'd7;
            3'd4:    tap = 4'd8;
            3'd5:    tap = 4'd9;
            3'd6:    tap = 4'd11;
            default: tap = 4'd12;
        endcase
        return tap;
    endfunction

endpackage

// File: rtl/sh7604_stby_settle.sv
// rtl/sh7604_stby_settle.sv - oscillator settle timer: prescaler, 8-bit counter, CKS tap select
module sh7604_stby_settle
    import sh7604_stby_ctrl_pkg::*;
#(
    parameter logic [7:0] SETTLE_TOP = 8'hFF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE_R,
    input  logic       EN,
    input  logic       CLR,
    input  logic [2:0] CKS,
    output logic       OVF
);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [3:0]         tap_q, tap_d;
    logic [PRESC_W-1:0] tap_mask;
    logic               tap_hit;

    always_comb begin
        for (int i = 0; i < PRESC_W; i++) begin
            tap_mask[i] = (i <= int'(tap_q));
        end
    end

    // The counter advances once every 2^(tap+1) prescaler steps, when all low bits are set.
    assign tap_hit = ((presc_q & tap_mask) == tap_mask);
    assign OVF     = tap_hit && (cnt_q == SETTLE_TOP);

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        tap_d   = tap_q;
        if (CE_R) begin
            if (CLR) begin
                presc_d = '0;
                cnt_d   = '0;
                tap_d   = cks_tap(CKS);
            end else if (EN) begin
                presc_d = presc_q + PRESC_W'(1);
                if (tap_hit) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q <= '0;
            cnt_q   <= '0;
            tap_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            tap_q   <= tap_d;
        end
    end

endmodule

// File: rtl/sh7604_stby_ctrl.sv
// rtl/sh7604_stby_ctrl.sv - SLEEP/STANDBY power-down sequencer with wake tracking and settle timing
module sh7604_stby_ctrl
    import sh7604_stby_ctrl_pkg::*;
#(
    parameter logic [7:0] SETTLE_TOP = 8'hFF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE_R,
    input  logic       CE_F,
    input  logic       EN,
    input  logic       RES_N,
    input  logic       SBY,
    input  logic       SLEEP_REQ,
    input  logic       BUS_IDLE,
    input  logic       IRQ_PEND,
    input  logic       NMI,
    input  logic [2:0] WDT_CKS,
    output logic       SLEEP_ACK,
    output logic       CPU_STOP,
    output logic       CLK_STOP,
    output logic       PERIPH_RST,
    output logic       WAKE,
    output logic       STBY_ACT
);

    stby_state_t state_q, state_d, next_state;
    logic nmi_d_q, nmi_d_d;
    logic nmi_pend_q, nmi_pend_d;
    logic req_arm_q, req_arm_d;
    logic ack_q, ack_d;
    logic wake_q, wake_d;
    logic act_q, act_d;
    logic tick, soft_rst, nmi_edge, ack_set, wake_set;
    logic settle_clr, settle_ovf;

    assign tick     = CE_R && EN;
    assign soft_rst = CE_R && !RES_N;
    assign nmi_edge = nmi_d_q && !NMI;

    // Soft reset also wipes the settle timer so a later standby starts from zero.
    assign settle_clr = soft_rst || (tick && (state_q == ST_STBY) && nmi_pend_q);

    sh7604_stby_settle #(
        .SETTLE_TOP (SETTLE_TOP)
    ) u_settle (
        .CLK  (CLK),
        .RST  (RST),
        .CE_R (CE_R),
        .EN   (EN),
        .CLR  (settle_clr),
        .CKS  (WDT_CKS),
        .OVF  (settle_ovf)
    );

    always_comb begin
        next_state = state_q;
        ack_set    = 1'b0;
        wake_set   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (SLEEP_REQ && req_arm_q) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (BUS_IDLE) begin
                    ack_set    = 1'b1;
                    next_state = SBY ? ST_STBY : ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (IRQ_PEND || nmi_pend_q) begin
                    wake_set   = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_STBY: begin
                if (nmi_pend_q) next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_ovf) begin
                    wake_set   = 1'b1;
                    next_state = ST_RUN;
                end
            end
            default: next_state = ST_RUN;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        nmi_d_d    = nmi_d_q;
        nmi_pend_d = nmi_pend_q;
        req_arm_d  = req_arm_q;
        ack_d      = ack_q;
        wake_d     = wake_q;
        act_d      = act_q;
        if (soft_rst) begin
            state_d    = ST_RUN;
            nmi_d_d    = 1'b0;
            nmi_pend_d = 1'b0;
            req_arm_d  = 1'b1;
            ack_d      = 1'b0;
            wake_d     = 1'b0;
            act_d      = 1'b0;
        end else begin
            if (CE_F && EN) act_d = (state_q != ST_RUN);
            if (tick) begin
                state_d    = next_state;
                ack_d      = ack_set;
                wake_d     = wake_set;
                nmi_d_d    = NMI;
                nmi_pend_d = (nmi_pend_q || nmi_edge) && (next_state != ST_RUN);
                // A held SLEEP_REQ must drop before it can start another drain.
                if (!SLEEP_REQ) begin
                    req_arm_d = 1'b1;
                end else if ((state_q == ST_RUN) && (next_state == ST_DRAIN)) begin
                    req_arm_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_RUN;
            nmi_d_q    <= 1'b0;
            nmi_pend_q <= 1'b0;
            req_arm_q  <= 1'b1;
            ack_q      <= 1'b0;
            wake_q     <= 1'b0;
            act_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nmi_d_q    <= nmi_d_d;
            nmi_pend_q <= nmi_pend_d;
            req_arm_q  <= req_arm_d;
            ack_q      <= ack_d;
            wake_q     <= wake_d;
            act_q      <= act_d;
        end
    end

    assign CPU_STOP   = (state_q != ST_RUN);
    assign CLK_STOP   = (state_q == ST_STBY) || (state_q == ST_SETTLE);
    assign PERIPH_RST = (state_q == ST_STBY);
    assign SLEEP_ACK  = ack_q;
    assign WAKE       = wake_q;
    assign STBY_ACT   = act_q;

endmodule

// File: tb/tb_sh7604_stby_ctrl.sv
// tb/tb_sh7604_stby_ctrl.sv - scoreboard bench for the standby sequencer against a behavioural model
module tb_sh7604_stby_ctrl;

    localparam int M_RUN = 0, M_DRAIN = 1, M_SLEEP = 2, M_STBY = 3, M_SETTLE = 4;
    localparam int EV_ACK = 0, EV_WAKE = 1;

    logic clk = 1'b0;
    logic rst, ce_r, ce_f, en, res_n, sby, req, idle, irq, nmi;
    logic [2:0] cks;
    logic sleep_ack, cpu_stop, clk_stop, periph_rst, wake, stby_act;

    always #5 clk = ~clk;

    sh7604_stby_ctrl dut (
        .CLK        (clk),
        .RST        (rst),
        .CE_R       (ce_r),
        .CE_F       (ce_f),
        .EN         (en),
        .RES_N      (res_n),
        .SBY        (sby),
        .SLEEP_REQ  (req),
        .BUS_IDLE   (idle),
        .IRQ_PEND   (irq),
        .NMI        (nmi),
        .WDT_CKS    (cks),
        .SLEEP_ACK  (sleep_ack),
        .CPU_STOP   (cpu_stop),
        .CLK_STOP   (clk_stop),
        .PERIPH_RST (periph_rst),
        .WAKE       (wake),
        .STBY_ACT   (stby_act)
    );

    typedef struct {
        int kind;
        int tick;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  tick_cnt = 0;
    int  m_mode, m_left;
    bit  m_prev, m_pend, m_arm, m_act;
    bit  en_rand = 0;

    function automatic int div_of(input int c);
        case (c)
            0: return 2;
            1: return 64;
            2: return 128;
            3: return 256;
            4: return 512;
            5: return 1024;
            6: return 4096;
            default: return 8192;
        endcase
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tick_cnt);
        end
    endfunction

    function automatic void model_reset();
        m_mode = M_RUN;
        m_left = 0;
        m_prev = 1'b0;
        m_pend = 1'b0;
        m_arm  = 1'b1;
        m_act  = 1'b0;
    endfunction

    // Called once per clock edge with the inputs that the DUT sampled at that edge.
    function automatic void model_step();
        int nxt;
        bit edge_seen;
        if (rst || (ce_r && !res_n)) begin
            model_reset();
            return;
        end
        if (ce_f && en) m_act = (m_mode != M_RUN);
        if (!(ce_r && en)) return;
        edge_seen = m_prev && !nmi;
        m_prev = nmi;
        nxt = m_mode;
        case (m_mode)
            M_RUN:    if (req && m_arm) nxt = M_DRAIN;
            M_DRAIN:  if (idle) begin
                          exp_q.push_back('{EV_ACK, tick_cnt});
                          nxt = sby ? M_STBY : M_SLEEP;
                      end
            M_SLEEP:  if (irq || m_pend) begin
                          exp_q.push_back('{EV_WAKE, tick_cnt});
                          nxt = M_RUN;
                      end
            M_STBY:   if (m_pend) begin
                          nxt = M_SETTLE;
                          m_left = 256 * div_of(int'(cks));
                      end
            default:  begin
                          m_left--;
                          if (m_left == 0) begin
                              exp_q.push_back('{EV_WAKE, tick_cnt});
                              nxt = M_RUN;
                          end
                      end
        endcase
        if (!req) m_arm = 1'b1;
        else if (m_mode == M_RUN && nxt == M_DRAIN) m_arm = 1'b0;
        m_pend = (m_pend || edge_seen) && (nxt != M_RUN);
        m_mode = nxt;
    endfunction

    function automatic int exp_levels();
        int v;
        v = 0;
        if (m_mode != M_RUN) v |= 8;
        if (m_mode == M_STBY || m_mode == M_SETTLE) v |= 4;
        if (m_mode == M_STBY) v |= 2;
        if (m_act) v |= 1;
        return v;
    endfunction

    task automatic cycle();
        ce_r = ($urandom_range(0, 4) != 0);
        ce_f = ($urandom_range(0, 1) != 0);
        if (en_rand) en = ($urandom_range(0, 7) != 0);
        @(posedge clk);
        if (ce_r) tick_cnt++;
        model_step();
        #1;
        check("levels{cpu,clk,prst,act}", int'({cpu_stop, clk_stop, periph_rst, stby_act}), exp_levels());
    endtask

    task automatic ticks(input int n);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 100000) begin
            cycle();
            if (ce_r && en) k++;
            guard++;
        end
    endtask

    task automatic wait_mode(input int m, input int limit);
        int guard = 0;
        while (m_mode != m && guard < limit) begin
            cycle();
            guard++;
        end
        check("wait_mode_reached", int'(m_mode == m), 1);
    endtask

    task automatic enter_stby(input int c);
        sby = 1'b1; cks = 3'(c); req = 1'b0; idle = 1'b0;
        ticks(1);
        req = 1'b1;
        ticks(1);
        idle = 1'b1;
        wait_mode(M_STBY, 100);
        idle = 1'b0;
        req = 1'b0;
        nmi = 1'b0;
        ticks(2);
        nmi = 1'b1;
        wait_mode(M_SETTLE, 100);
    endtask

    // Monitor: every rising SLEEP_ACK / WAKE pops the scoreboard.
    function automatic void pop_ev(input int kind);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL pulse_unexpected: got kind %0d at tick %0d expected none", kind, tick_cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.tick != tick_cnt) begin
                n_bad++;
                $display("FAIL pulse: got kind %0d tick %0d expected kind %0d tick %0d",
                         kind, tick_cnt, e.kind, e.tick);
            end
        end
    endfunction

    initial begin
        bit prev_a = 1'b0;
        bit prev_w = 1'b0;
        forever begin
            @(negedge clk);
            if (sleep_ack && !prev_a) pop_ev(EV_ACK);
            if (wake && !prev_w) pop_ev(EV_WAKE);
            prev_a = sleep_ack;
            prev_w = wake;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; res_n = 1'b1; sby = 1'b0; req = 1'b0; idle = 1'b0;
        irq = 1'b0; nmi = 1'b1; cks = 3'd0; ce_r = 1'b0; ce_f = 1'b0;
        model_reset();
        repeat (3) cycle();
        check("reset_outputs", int'({sleep_ack, cpu_stop, clk_stop, periph_rst, wake, stby_act}), 0);
        rst = 1'b0;
        ticks(2);

        // SLEEP entry after a three-tick drain, IRQ wake, held request does not re-enter.
        req = 1'b1;
        ticks(1);
        ticks(2);
        idle = 1'b1;
        ticks(1);
        idle = 1'b0;
        check("sleep_cpu_stop", int'(cpu_stop), 1);
        check("sleep_clk_stop", int'(clk_stop), 0);
        ticks(5);
        irq = 1'b1;
        ticks(1);
        irq = 1'b0;
        check("wake_run", int'(cpu_stop), 0);
        ticks(20);
        check("held_req_no_reentry", int'(cpu_stop), 0);
        req = 1'b0;
        ticks(2);

        // STANDBY with IRQ noise ignored, SBY change ignored, CKS=0 settle.
        sby = 1'b1; cks = 3'd0; req = 1'b1;
        ticks(1);
        idle = 1'b1;
        ticks(1);
        idle = 1'b0; sby = 1'b0; irq = 1'b1;
        ticks(1000);
        check("stby_irq_ignored_clk_stop", int'(clk_stop), 1);
        check("stby_periph_rst", int'(periph_rst), 1);
        irq = 1'b0; req = 1'b0; nmi = 1'b0;
        ticks(2);
        nmi = 1'b1;
        ticks(1);
        check("settle_periph_rst_low", int'(periph_rst), 0);
        wait_mode(M_RUN, 2000);
        ticks(3);

        // CKS=1 settle with CKS changed mid-way and random EN freezing.
        en_rand = 1;
        enter_stby(1);
        ticks(100);
        cks = 3'd0;
        wait_mode(M_RUN, 40000);
        en_rand = 0; en = 1'b1;
        ticks(3);

        // RES_N pulse at settle count 0x40.
        enter_stby(0);
        while (m_mode == M_SETTLE && m_left > 512 - 128) cycle();
        res_n = 1'b0;
        ticks(1);
        res_n = 1'b1;
        check("resn_outputs", int'({sleep_ack, cpu_stop, clk_stop, periph_rst, wake, stby_act}), 0);
        ticks(5);

        // Asynchronous RST mid-settle.
        enter_stby(0);
        ticks(50);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_outputs", int'({sleep_ack, cpu_stop, clk_stop, periph_rst, wake, stby_act}), 0);
        cycle();
        cycle();
        rst = 1'b0;
        ticks(3);

        // NMI edge during DRAIN: one SLEEP tick, then RUN; held request ignored.
        sby = 1'b0; req = 1'b1; idle = 1'b0;
        ticks(1);
        nmi = 1'b0;
        ticks(1);
        nmi = 1'b1; idle = 1'b1;
        ticks(1);
        idle = 1'b0;
        check("nmi_drain_sleep", int'(cpu_stop), 1);
        ticks(1);
        check("nmi_drain_run", int'(cpu_stop), 0);
        ticks(10);
        req = 1'b0;
        ticks(2);

        // Randomised cycles through both power-down modes and wake sources.
        en_rand = 1;
        for (int it = 0; it < 8; it++) begin
            int choice;
            sby = ($urandom_range(0, 1) != 0);
            cks = 3'd0;
            req = 1'b0;
            ticks(1);
            req = 1'b1;
            ticks($urandom_range(1, 4));
            idle = 1'b1;
            ticks(1);
            idle = 1'b0;
            req = ($urandom_range(0, 1) != 0);
            ticks($urandom_range(1, 5));
            choice = sby ? 1 : $urandom_range(0, 2);
            if (choice != 1) irq = 1'b1;
            if (choice != 0) nmi = 1'b0;
            ticks(2);
            irq = 1'b0; nmi = 1'b1;
            wait_mode(M_RUN, 3000);
            req = 1'b0;
            ticks(2);
        end
        en_rand = 0; en = 1'b1;
        ticks(5);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
